// File: rtl/reg_file_mp.sv
// Two-write / two-read register file with a clear sequencer that zeroes one entry per cycle,
// an optional write-to-read bypass and an optional hardwired zero entry.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    we0, we1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt wraps back to 0 on the last sweep edge, so IDLE always starts from 0
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_done  = 1'b0;
        case (state)
            CLEAR: begin
                busy    = 1'b1;
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                if (cnt == LAST) begin
                    clr_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (clr_req) state_nxt = CLEAR;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Effective write strobes: suppressed during the sweep and for the hardwired zero entry
    assign we0 = wen0 && (state == IDLE) && !((ZERO_REG != 0) && (waddr0 == '0));
    assign we1 = wen1 && (state == IDLE) && !((ZERO_REG != 0) && (waddr1 == '0));

    // Port 1 is written last so it wins an address collision
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (we0) mem[waddr0] <= wdata0;
            if (we1) mem[waddr1] <= wdata1;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] d;
        d = mem[a];
        if (state != IDLE)
            d = '0;
        else if ((ZERO_REG != 0) && (a == '0))
            d = '0;
        else if ((BYPASS != 0) && we1 && (waddr1 == a))
            d = wdata1;
        else if ((BYPASS != 0) && we0 && (waddr0 == a))
            d = wdata0;
        return d;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypass/zero-reg instance and a plain instance share all inputs
// and are checked against table rows and hand-written clear/reset sequences.
module tb_reg_file_mp;

    logic        clk, rst;
    logic        wen0, wen1, clr_req;
    logic [4:0]  waddr0, waddr1, raddr1, raddr2;
    logic [31:0] wdata0, wdata1;
    logic [31:0] rdata1, rdata2, rdata1_b, rdata2_b;
    logic        busy, clr_done, busy_b, clr_done_b;

    int checks   = 0;
    int failures = 0;

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .rdata1(rdata1_b), .raddr2(raddr2), .rdata2(rdata2_b),
        .clr_req(clr_req), .busy(busy_b), .clr_done(clr_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        w1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        clr;
        logic [31:0] e1, e2, e1b, e2b;
        logic        ebusy, edone;
    } vec_t;

    typedef struct {
        logic [31:0] e1, e2, e1b, e2b;
        logic        ebusy, edone;
        int          id;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mk(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] ra1, input logic [4:0] ra2, input logic clr,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] e1b, input logic [31:0] e2b,
                                input logic eb, input logic ed);
        vec_t v;
        v.w0 = w0; v.a0 = a0; v.d0 = d0; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.ra1 = ra1; v.ra2 = ra2; v.clr = clr;
        v.e1 = e1; v.e2 = e2; v.e1b = e1b; v.e2b = e2b; v.ebusy = eb; v.edone = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s id=%0d actual=%h required=%h", nm, id, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, score it mid-cycle, return just after the next rising edge
    task automatic step(input vec_t v, input int id);
        exp_t e;
        wen0 = v.w0; waddr0 = v.a0; wdata0 = v.d0;
        wen1 = v.w1; waddr1 = v.a1; wdata1 = v.d1;
        raddr1 = v.ra1; raddr2 = v.ra2; clr_req = v.clr;
        e.e1 = v.e1; e.e2 = v.e2; e.e1b = v.e1b; e.e2b = v.e2b;
        e.ebusy = v.ebusy; e.edone = v.edone; e.id = id;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk("rdata1",     e.id, rdata1,            e.e1);
        chk("rdata2",     e.id, rdata2,            e.e2);
        chk("rdata1_b",   e.id, rdata1_b,          e.e1b);
        chk("rdata2_b",   e.id, rdata2_b,          e.e2b);
        chk("busy",       e.id, {31'd0, busy},     {31'd0, e.ebusy});
        chk("clr_done",   e.id, {31'd0, clr_done}, {31'd0, e.edone});
        chk("busy_b",     e.id, {31'd0, busy_b},   {31'd0, e.ebusy});
        chk("clr_done_b", e.id, {31'd0, clr_done_b}, {31'd0, e.edone});
        @(posedge clk);
        #1;
    endtask

    // Full 32-cycle sweep; optional write to addr 5 and clr_req at the given sweep cycle
    task automatic sweep(input int id_base, input int write_at, input int clr_at);
        for (int k = 1; k <= 32; k++)
            step(mk(k == write_at, 5'd5, 32'h0000_0BAD, 1'b0, 5'd0, 32'd0,
                    5'(k - 1), 5'd5, k == clr_at,
                    32'd0, 32'd0, 32'd0, 32'd0, 1'b1, k == 32), id_base + k);
    endtask

    task automatic read_all_zero(input int id_base);
        for (int i = 0; i < 32; i++)
            step(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0,
                    32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0), id_base + i);
    endtask

    vec_t tbl[10];

    initial begin
        //           w0  a0  d0            w1  a1  d1            ra1 ra2 clr  e1            e2            e1b           e2b           busy done
        tbl[0] = mk(1, 3, 32'hDEADBEEF, 0, 0, 32'h0,        3, 0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        0, 0);
        tbl[1] = mk(0, 0, 32'h0,        0, 0, 32'h0,        3, 3, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        tbl[2] = mk(1, 7, 32'h11,       1, 7, 32'h22,       7, 7, 0, 32'h22,       32'h22,       32'h0,        32'h0,        0, 0);
        tbl[3] = mk(0, 0, 32'h0,        0, 0, 32'h0,        7, 3, 0, 32'h22,       32'hDEADBEEF, 32'h22,       32'hDEADBEEF, 0, 0);
        tbl[4] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 7, 0, 32'h0,        32'h22,       32'h0,        32'h22,       0, 0);
        tbl[5] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        tbl[6] = mk(1, 9, 32'hA5A5A5A5, 1, 0, 32'h12345678, 9, 0, 0, 32'hA5A5A5A5, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 0);
        tbl[7] = mk(0, 0, 32'h0,        0, 0, 32'h0,        9, 0, 0, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h12345678, 0, 0);
        tbl[8] = mk(1, 4, 32'h44,       1, 5, 32'h55,       4, 5, 0, 32'h44,       32'h55,       32'h0,        32'h0,        0, 0);
        tbl[9] = mk(0, 0, 32'h0,        0, 0, 32'h0,        5, 4, 0, 32'h55,       32'h44,       32'h55,       32'h44,       0, 0);

        rst = 1'b1;
        wen0 = 0; wen1 = 0; clr_req = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; raddr1 = 0; raddr2 = 0;
        @(posedge clk);
        #1;

        // T1: reset state, then a 32-cycle sweep after release
        for (int i = 0; i < 2; i++)
            step(mk(1'b1, 5'd3, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1,
                    32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0), 100 + i);
        rst = 1'b0;
        sweep(200, 0, 0);
        read_all_zero(300);

        // T2-T4: table of idle read/write vectors
        for (int i = 0; i < 10; i++)
            step(tbl[i], 400 + i);

        // T5: fill 1..31 with their index, read back, then clear with disturbances mid-sweep
        for (int i = 1; i < 32; i++) begin
            wen0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(i);
            wen1 = 1'b0; clr_req = 1'b0;
            @(posedge clk);
            #1;
        end
        step(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0,
                32'd0, 32'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b0), 500);
        for (int i = 1; i < 32; i++)
            step(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 1'b0,
                    32'(i), 32'(i), 32'(i), 32'(i), 1'b0, 1'b0), 500 + i);
        step(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b1,
                32'd1, 32'd31, 32'd1, 32'd31, 1'b0, 1'b0), 600);
        sweep(600, 20, 10);
        read_all_zero(700);

        // T6: reset in the middle of a sweep restarts it from entry 0
        step(mk(1'b1, 5'd8, 32'h8888, 1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 1'b1,
                32'h8888, 32'h8888, 32'd0, 32'd0, 1'b0, 1'b0), 800);
        for (int k = 1; k <= 10; k++)
            step(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 1'b0,
                    32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0), 800 + k);
        rst = 1'b1;
        #1;
        chk("busy_in_rst",     900, {31'd0, busy},     32'd1);
        chk("clr_done_in_rst", 900, {31'd0, clr_done}, 32'd0);
        @(posedge clk);
        #1;
        step(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 1'b0,
                32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0), 901);
        rst = 1'b0;
        sweep(1000, 0, 0);
        read_all_zero(1100);
        step(mk(1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 32'd0, 5'd2, 5'd8, 1'b0,
                32'h77, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0), 1200);
        step(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd2, 1'b0,
                32'h77, 32'h77, 32'h77, 32'h77, 1'b0, 1'b0), 1201);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
